// File: rtl/mmio_memory.sv
// CPU data-port memory map: general RAM, screen RAM with a registered write-through
// port to the display, and an I/O window in front of a keyboard FIFO.
module mmio_memory #(
   parameter int WIDTH     = 16,
   parameter int ADDR_W    = 15,
   parameter int KBD_DEPTH = 4,
   parameter int KBD_AW    = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [WIDTH-1:0]    in,
   input  logic                load,
   input  logic [ADDR_W-1:0]   address,
   output logic [WIDTH-1:0]    out,
   input  logic [WIDTH-1:0]    kbd_data,
   input  logic                kbd_valid,
   output logic                kbd_ready,
   output logic [KBD_AW:0]     kbd_count,
   output logic                scr_we,
   output logic [ADDR_W-3:0]   scr_addr,
   output logic [WIDTH-1:0]    scr_data
);

   localparam int RAM_WORDS = 2 ** (ADDR_W - 1);
   localparam int SCR_WORDS = 2 ** (ADDR_W - 2);
   localparam logic [KBD_AW:0] FULL_CNT = (KBD_AW + 1)'(KBD_DEPTH);

   logic [WIDTH-1:0] ram_mem [RAM_WORDS];
   logic [WIDTH-1:0] scr_mem [SCR_WORDS];
   logic [WIDTH-1:0] kbd_mem [KBD_DEPTH];

   logic [KBD_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [KBD_AW:0]   count_q, count_d;
   logic              scr_we_q, scr_we_d;
   logic [ADDR_W-3:0] scr_addr_q, scr_addr_d;
   logic [WIDTH-1:0]  scr_data_q, scr_data_d;

   logic [1:0]        region;
   logic [ADDR_W-3:0] off;
   logic [ADDR_W-2:0] ram_idx;
   logic              is_ram, is_scr, is_io;
   logic              kbd_empty, kbd_full, push, pop;

   always_comb begin
      region    = address[ADDR_W-1:ADDR_W-2];
      off       = address[ADDR_W-3:0];
      ram_idx   = address[ADDR_W-2:0];
      is_ram    = ~region[1];
      is_scr    = (region == 2'b10);
      is_io     = (region == 2'b11);
      kbd_empty = (count_q == '0);
      kbd_full  = (count_q == FULL_CNT);
      // kbd_valid/kbd_ready form a plain valid/ready pair: a code transfers on any
      // rising edge where both are high; ready depends only on the stored count.
      push      = kbd_valid && !kbd_full;
      pop       = load && is_io && (off == '0) && !kbd_empty;

      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;

      scr_we_d   = load && is_scr;
      scr_addr_d = scr_we_d ? off : scr_addr_q;
      scr_data_d = scr_we_d ? in  : scr_data_q;

      out = '0;
      if (is_ram) begin
         out = ram_mem[ram_idx];
      end else if (is_scr) begin
         out = scr_mem[off];
      end else if (off == '0) begin
         out = kbd_empty ? '0 : kbd_mem[rd_ptr_q];
      end else if (off == (ADDR_W-2)'(1)) begin
         out[KBD_AW:0] = count_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         scr_we_q   <= 1'b0;
         scr_addr_q <= '0;
         scr_data_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         scr_we_q   <= scr_we_d;
         scr_addr_q <= scr_addr_d;
         scr_data_q <= scr_data_d;
      end
   end

   // Storage arrays have no reset; reset only blocks writes in its own cycle.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (load && is_ram) ram_mem[ram_idx] <= in;
         if (load && is_scr) scr_mem[off] <= in;
         if (push) kbd_mem[wr_ptr_q] <= kbd_data;
      end
   end

   assign kbd_ready = !kbd_full;
   assign kbd_count = count_q;
   assign scr_we    = scr_we_q;
   assign scr_addr  = scr_addr_q;
   assign scr_data  = scr_data_q;

endmodule

// File: tb/tb_mmio_memory.sv
// Directed bench for mmio_memory: a table of per-cycle vectors for RAM, screen and
// keyboard FIFO behaviour, then a hand-written reset-in-the-middle sequence.
module tb_mmio_memory;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] in;
   logic        load;
   logic [14:0] address;
   logic [15:0] out;
   logic [15:0] kbd_data;
   logic        kbd_valid;
   logic        kbd_ready;
   logic [2:0]  kbd_count;
   logic        scr_we;
   logic [12:0] scr_addr;
   logic [15:0] scr_data;

   int n_cmp  = 0;
   int n_fail = 0;

   mmio_memory dut (
      .clock     (clock),
      .reset     (reset),
      .in        (in),
      .load      (load),
      .address   (address),
      .out       (out),
      .kbd_data  (kbd_data),
      .kbd_valid (kbd_valid),
      .kbd_ready (kbd_ready),
      .kbd_count (kbd_count),
      .scr_we    (scr_we),
      .scr_addr  (scr_addr),
      .scr_data  (scr_data)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        ld;
      logic [14:0] addr;
      logic [15:0] wd;
      logic        kv;
      logic [15:0] kd;
      logic        chk_out;
      logic [15:0] exp_out;
      logic [2:0]  exp_cnt;
      logic        exp_rdy;
      logic        exp_we;
      logic [12:0] exp_sa;
      logic [15:0] exp_sd;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic ld, input logic [14:0] addr, input logic [15:0] wd,
                      input logic kv, input logic [15:0] kd, input logic chk_out,
                      input logic [15:0] eo, input logic [2:0] ec, input logic ew,
                      input logic [12:0] esa, input logic [15:0] esd);
      vec_t v;
      v.ld = ld; v.addr = addr; v.wd = wd; v.kv = kv; v.kd = kd;
      v.chk_out = chk_out; v.exp_out = eo; v.exp_cnt = ec;
      v.exp_rdy = (ec != 3'd4);
      v.exp_we = ew; v.exp_sa = esa; v.exp_sd = esd;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ld, input logic [14:0] addr, input logic [15:0] wd,
                        input logic kv, input logic [15:0] kd);
      @(negedge clock);
      load = ld; address = addr; in = wd; kbd_valid = kv; kbd_data = kd;
      #1;
   endtask

   task automatic check_state(input string tag, input logic [2:0] ec, input logic ew,
                              input logic [12:0] esa, input logic [15:0] esd);
      check({tag, " cnt"}, 32'(kbd_count), 32'(ec));
      check({tag, " rdy"}, 32'(kbd_ready), 32'(ec != 3'd4));
      check({tag, " scr_we"}, 32'(scr_we), 32'(ew));
      check({tag, " scr_addr"}, 32'(scr_addr), 32'(esa));
      check({tag, " scr_data"}, 32'(scr_data), 32'(esd));
   endtask

   initial begin
      reset = 1'b1; load = 1'b0; address = '0; in = '0; kbd_valid = 1'b0; kbd_data = '0;

      // RAM write/read; 0x2005 is a separate RAM word from 0x0005
      add(1, 15'h0005, 16'h1234, 0, 0, 0, 16'h0000, 0, 0, 13'h0000, 16'h0000);
      add(0, 15'h0005, 16'h0000, 0, 0, 1, 16'h1234, 0, 0, 13'h0000, 16'h0000);
      add(1, 15'h2005, 16'hABCD, 0, 0, 0, 16'h0000, 0, 0, 13'h0000, 16'h0000);
      add(0, 15'h0005, 16'h0000, 0, 0, 1, 16'h1234, 0, 0, 13'h0000, 16'h0000);
      add(0, 15'h2005, 16'h0000, 0, 0, 1, 16'hABCD, 0, 0, 13'h0000, 16'h0000);
      // Screen write-through, single and back-to-back strobes
      add(1, 15'h4010, 16'hFFFF, 0, 0, 0, 16'h0000, 0, 0, 13'h0000, 16'h0000);
      add(0, 15'h4010, 16'h0000, 0, 0, 1, 16'hFFFF, 0, 1, 13'h0010, 16'hFFFF);
      add(0, 15'h0005, 16'h0000, 0, 0, 1, 16'h1234, 0, 0, 13'h0010, 16'hFFFF);
      add(1, 15'h4011, 16'h0001, 0, 0, 0, 16'h0000, 0, 0, 13'h0010, 16'hFFFF);
      add(1, 15'h4012, 16'h0002, 0, 0, 0, 16'h0000, 0, 1, 13'h0011, 16'h0001);
      add(0, 15'h4011, 16'h0000, 0, 0, 1, 16'h0001, 0, 1, 13'h0012, 16'h0002);
      add(0, 15'h4012, 16'h0000, 0, 0, 1, 16'h0002, 0, 0, 13'h0012, 16'h0002);
      // Screen word 0x4005 does not disturb RAM word 0x0005
      add(1, 15'h4005, 16'h5555, 0, 0, 0, 16'h0000, 0, 0, 13'h0012, 16'h0002);
      add(0, 15'h0005, 16'h0000, 0, 0, 1, 16'h1234, 0, 1, 13'h0005, 16'h5555);
      add(0, 15'h4005, 16'h0000, 0, 0, 1, 16'h5555, 0, 0, 13'h0005, 16'h5555);
      // Empty FIFO head, pop on empty, count window
      add(0, 15'h6000, 16'h0000, 0, 0, 1, 16'h0000, 0, 0, 13'h0005, 16'h5555);
      add(1, 15'h6000, 16'h0000, 0, 0, 1, 16'h0000, 0, 0, 13'h0005, 16'h5555);
      add(0, 15'h6001, 16'h0000, 0, 0, 1, 16'h0000, 0, 0, 13'h0005, 16'h5555);
      // Fill to full; 0x45 held off until a pop frees a slot
      add(0, 15'h6000, 16'h0000, 1, 16'h0041, 1, 16'h0000, 0, 0, 13'h0005, 16'h5555);
      add(0, 15'h6000, 16'h0000, 1, 16'h0042, 1, 16'h0041, 1, 0, 13'h0005, 16'h5555);
      add(0, 15'h6000, 16'h0000, 1, 16'h0043, 1, 16'h0041, 2, 0, 13'h0005, 16'h5555);
      add(0, 15'h6000, 16'h0000, 1, 16'h0044, 1, 16'h0041, 3, 0, 13'h0005, 16'h5555);
      add(0, 15'h6000, 16'h0000, 1, 16'h0045, 1, 16'h0041, 4, 0, 13'h0005, 16'h5555);
      add(0, 15'h6001, 16'h0000, 1, 16'h0045, 1, 16'h0004, 4, 0, 13'h0005, 16'h5555);
      add(1, 15'h6000, 16'h0000, 1, 16'h0045, 1, 16'h0041, 4, 0, 13'h0005, 16'h5555);
      add(0, 15'h6000, 16'h0000, 1, 16'h0045, 1, 16'h0042, 3, 0, 13'h0005, 16'h5555);
      add(0, 15'h6000, 16'h0000, 0, 16'h0000, 1, 16'h0042, 4, 0, 13'h0005, 16'h5555);
      add(1, 15'h6000, 16'h0000, 0, 16'h0000, 1, 16'h0042, 4, 0, 13'h0005, 16'h5555);
      add(1, 15'h6000, 16'h0000, 0, 16'h0000, 1, 16'h0043, 3, 0, 13'h0005, 16'h5555);
      add(1, 15'h6000, 16'h0000, 0, 16'h0000, 1, 16'h0044, 2, 0, 13'h0005, 16'h5555);
      add(0, 15'h6001, 16'h0000, 0, 16'h0000, 1, 16'h0001, 1, 0, 13'h0005, 16'h5555);
      add(1, 15'h6000, 16'h0000, 0, 16'h0000, 1, 16'h0045, 1, 0, 13'h0005, 16'h5555);
      add(0, 15'h6000, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 0, 13'h0005, 16'h5555);
      // Push+pop with one entry, then push+pop on empty (only the push lands)
      add(0, 15'h6000, 16'h0000, 1, 16'h0051, 1, 16'h0000, 0, 0, 13'h0005, 16'h5555);
      add(1, 15'h6000, 16'h0000, 1, 16'h0052, 1, 16'h0051, 1, 0, 13'h0005, 16'h5555);
      add(0, 15'h6000, 16'h0000, 0, 16'h0000, 1, 16'h0052, 1, 0, 13'h0005, 16'h5555);
      add(1, 15'h6000, 16'h0000, 0, 16'h0000, 1, 16'h0052, 1, 0, 13'h0005, 16'h5555);
      add(1, 15'h6000, 16'h0000, 1, 16'h0053, 1, 16'h0000, 0, 0, 13'h0005, 16'h5555);
      add(0, 15'h6000, 16'h0000, 0, 16'h0000, 1, 16'h0053, 1, 0, 13'h0005, 16'h5555);
      // Count window, unused I/O offsets, ignored I/O writes
      add(0, 15'h6001, 16'h0000, 1, 16'h0054, 1, 16'h0001, 1, 0, 13'h0005, 16'h5555);
      add(0, 15'h6001, 16'h0000, 0, 16'h0000, 1, 16'h0002, 2, 0, 13'h0005, 16'h5555);
      add(0, 15'h6002, 16'h0000, 0, 16'h0000, 1, 16'h0000, 2, 0, 13'h0005, 16'h5555);
      add(1, 15'h6001, 16'hFFFF, 0, 16'h0000, 1, 16'h0002, 2, 0, 13'h0005, 16'h5555);
      add(1, 15'h6002, 16'hFFFF, 0, 16'h0000, 1, 16'h0000, 2, 0, 13'h0005, 16'h5555);
      add(0, 15'h6000, 16'h0000, 0, 16'h0000, 1, 16'h0053, 2, 0, 13'h0005, 16'h5555);
      add(0, 15'h6001, 16'h0000, 0, 16'h0000, 1, 16'h0002, 2, 0, 13'h0005, 16'h5555);

      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].ld, vecs[i].addr, vecs[i].wd, vecs[i].kv, vecs[i].kd);
         if (vecs[i].chk_out) check($sformatf("v%0d out", i), 32'(out), 32'(vecs[i].exp_out));
         check($sformatf("v%0d cnt", i), 32'(kbd_count), 32'(vecs[i].exp_cnt));
         check($sformatf("v%0d rdy", i), 32'(kbd_ready), 32'(vecs[i].exp_rdy));
         check($sformatf("v%0d scr_we", i), 32'(scr_we), 32'(vecs[i].exp_we));
         check($sformatf("v%0d scr_addr", i), 32'(scr_addr), 32'(vecs[i].exp_sa));
         check($sformatf("v%0d scr_data", i), 32'(scr_data), 32'(vecs[i].exp_sd));
      end

      // Reset mid-stream: 2 queued (53,54), add a third, preload RAM, then reset
      // with a RAM write, a screen write and a pending push all offered.
      drive(1, 15'h0030, 16'h1111, 1, 16'h0055);
      drive(0, 15'h0030, 16'h0000, 0, 16'h0000);
      check("pre-rst ram", 32'(out), 32'h1111);
      check_state("pre-rst", 3'd3, 1'b0, 13'h0005, 16'h5555);
      reset = 1'b1;
      drive(1, 15'h0030, 16'h2222, 1, 16'h0066);
      reset = 1'b1;
      drive(1, 15'h4020, 16'h7777, 1, 16'h0066);
      @(negedge clock);
      reset = 1'b0; load = 1'b0; kbd_valid = 1'b0; address = 15'h6000;
      #1;
      check("rst head", 32'(out), 32'h0);
      check_state("rst", 3'd0, 1'b0, 13'h0000, 16'h0000);
      drive(0, 15'h0030, 16'h0000, 0, 16'h0000);
      check("rst ram kept", 32'(out), 32'h1111);
      check_state("post-rst", 3'd0, 1'b0, 13'h0000, 16'h0000);
      // FIFO restarts cleanly after reset
      drive(0, 15'h6000, 16'h0000, 1, 16'h0077);
      drive(0, 15'h6000, 16'h0000, 0, 16'h0000);
      check("post-rst head", 32'(out), 32'h0077);
      check("post-rst cnt", 32'(kbd_count), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
